// File: rtl/rf_pkg.sv
// Shared encodings and the participation-mask helper for the parameterised register file.
// Vectors are big-endian: spec bit 0 / subfield 0 is the MSB of a [W-1:0] vector.
package rf_pkg;

   localparam logic [2:0] MODE_A = 3'b000;
   localparam logic [2:0] MODE_U = 3'b001;
   localparam logic [2:0] MODE_D = 3'b010;
   localparam logic [2:0] MODE_E = 3'b011;
   localparam logic [2:0] MODE_O = 3'b100;

   localparam logic [1:0] WW_8  = 2'b00;
   localparam logic [1:0] WW_16 = 2'b01;
   localparam logic [1:0] WW_32 = 2'b10;
   localparam logic [1:0] WW_64 = 2'b11;

   // Widest register the mask helper supports; callers slice down to their width.
   localparam int MAX_DW = 512;

   typedef struct packed {
      logic              legal;
      logic [MAX_DW-1:0] mask;
   } ppp_mask_t;

   function automatic ppp_mask_t ppp_mask(input logic [2:0] ppp_sel,
                                          input logic [1:0] ww,
                                          input int         dw);
      ppp_mask_t r;
      int        k;
      r.legal = (ppp_sel <= MODE_O);
      r.mask  = '0;
      for (int j = 0; j < MAX_DW; j++) begin
         if (j < dw) begin
            // subfield index counted from the MSB of the enclosing 64-bit lane
            k = (63 - (j % 64)) >> (3 + int'(ww));
            case (ppp_sel)
               MODE_A:  r.mask[j] = 1'b1;
               MODE_U:  r.mask[j] = (j >= dw / 2);
               MODE_D:  r.mask[j] = (j < dw / 2);
               MODE_E:  r.mask[j] = (k[0] == 1'b0);
               MODE_O:  r.mask[j] = (k[0] == 1'b1);
               default: r.mask[j] = 1'b0;
            endcase
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rf_write_mask.sv
// Combinational mask-and-merge for the write path; an illegal mode yields an all-zero
// mask so the merged value equals the old contents.
module rf_write_mask
   import rf_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic [DATA_WIDTH-1:0] old_i,
   input  logic [DATA_WIDTH-1:0] new_i,
   input  logic [2:0]            ppp_sel_i,
   input  logic [1:0]            ww_i,
   output logic [DATA_WIDTH-1:0] merged_o,
   output logic                  legal_o
);

   ppp_mask_t             pm;
   logic [DATA_WIDTH-1:0] mask;

   always_comb begin
      pm = ppp_mask(ppp_sel_i, ww_i, DATA_WIDTH);
   end

   assign mask     = pm.mask[DATA_WIDTH-1:0];
   assign legal_o  = pm.legal;
   assign merged_o = (new_i & mask) | (old_i & ~mask);

   if (DATA_WIDTH < MAX_DW) begin : g_pad
      logic unused_pad;
      assign unused_pad = |pm.mask[MAX_DW-1:DATA_WIDTH];
   end

endmodule

// File: rtl/param_register_file.sv
// Multi-port register file with masked merging writes, same-cycle write forwarding
// on every read port, and a per-register pending-write scoreboard.
module param_register_file
   import rf_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_RD     = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wrEn,
   input  logic [ADDR_WIDTH-1:0]        wr_addr,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic [2:0]                   PPP_sel,
   input  logic [1:0]                   WW,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   input  logic                         rsv_en,
   input  logic [ADDR_WIDTH-1:0]        rsv_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] data_out,
   output logic [NUM_RD-1:0]            rd_busy,
   output logic                         wr_err
);

   logic [DATA_WIDTH-1:0]        mem_q [DEPTH];
   logic [DEPTH-1:0]             busy_q, busy_d;
   logic [NUM_RD*DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic [NUM_RD-1:0]            rd_busy_q, rd_busy_d;
   logic                         wr_err_q, wr_err_d;

   logic [DATA_WIDTH-1:0]        merged;
   logic                         legal;
   logic                         wr_hit;
   logic                         wr_commit;

   rf_write_mask #(.DATA_WIDTH(DATA_WIDTH)) u_wmask (
      .old_i     (mem_q[wr_addr]),
      .new_i     (data_in),
      .ppp_sel_i (PPP_sel),
      .ww_i      (WW),
      .merged_o  (merged),
      .legal_o   (legal)
   );

   assign wr_hit    = wrEn && (wr_addr != '0);
   assign wr_commit = wr_hit && legal;
   assign wr_err_d  = wrEn && !legal;

   // Clear on write first so a same-cycle reservation of that register wins.
   always_comb begin
      busy_d = busy_q;
      if (wrEn)   busy_d[wr_addr]  = 1'b0;
      if (rsv_en) busy_d[rsv_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      assign ra = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_out_d[p*DATA_WIDTH +: DATA_WIDTH] =
         (wr_hit && (wr_addr == ra)) ? merged : mem_q[ra];
      assign rd_busy_d[p] = busy_d[ra];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         busy_q     <= '0;
         data_out_q <= '0;
         rd_busy_q  <= '0;
         wr_err_q   <= 1'b0;
      end else begin
         if (wr_commit) mem_q[wr_addr] <= merged;
         busy_q     <= busy_d;
         data_out_q <= data_out_d;
         rd_busy_q  <= rd_busy_d;
         wr_err_q   <= wr_err_d;
      end
   end

   assign data_out = data_out_q;
   assign rd_busy  = rd_busy_q;
   assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench: each stimulus cycle queues its hand-computed expected outputs, and a
// negedge monitor pops one entry per cycle and compares it against the DUT.
module tb_param_register_file;

   localparam int DW = 64;
   localparam int AW = 5;
   localparam int NR = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic               wrEn;
   logic [AW-1:0]      wr_addr;
   logic [DW-1:0]      data_in;
   logic [2:0]         PPP_sel;
   logic [1:0]         WW;
   logic [NR*AW-1:0]   rd_addr;
   logic               rsv_en;
   logic [AW-1:0]      rsv_addr;
   logic [NR*DW-1:0]   data_out;
   logic [NR-1:0]      rd_busy;
   logic               wr_err;

   param_register_file #(.DATA_WIDTH(DW), .DEPTH(32), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
      .clk      (clk),
      .reset    (reset),
      .wrEn     (wrEn),
      .wr_addr  (wr_addr),
      .data_in  (data_in),
      .PPP_sel  (PPP_sel),
      .WW       (WW),
      .rd_addr  (rd_addr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .data_out (data_out),
      .rd_busy  (rd_busy),
      .wr_err   (wr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [63:0] d0;
      logic [63:0] d1;
      logic [1:0]  b;
      logic        e;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string nm, input string fld, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s.%s got=%h want=%h", nm, fld, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (expq.size() > 0) begin
         mon_e = expq.pop_front();
         check(mon_e.nm, "data0",  data_out[63:0],   mon_e.d0);
         check(mon_e.nm, "data1",  data_out[127:64], mon_e.d1);
         check(mon_e.nm, "busy",   {62'd0, rd_busy}, {62'd0, mon_e.b});
         check(mon_e.nm, "wr_err", {63'd0, wr_err},  {63'd0, mon_e.e});
      end
   end

   task automatic step(input string nm, input bit rst, input bit we, input int wa,
                       input logic [63:0] din, input logic [2:0] ppp, input logic [1:0] ww,
                       input int r0, input int r1, input bit rv, input int ra,
                       input logic [63:0] e0, input logic [63:0] e1,
                       input logic [1:0] eb, input logic ee);
      exp_t x;
      reset    = rst;
      wrEn     = we;
      wr_addr  = wa[AW-1:0];
      data_in  = din;
      PPP_sel  = ppp;
      WW       = ww;
      rd_addr  = {r1[AW-1:0], r0[AW-1:0]};
      rsv_en   = rv;
      rsv_addr = ra[AW-1:0];
      x.nm = nm; x.d0 = e0; x.d1 = e1; x.b = eb; x.e = ee;
      expq.push_back(x);
      @(posedge clk);
      #1;
   endtask

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] Z    = 64'h0;

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //    name        rst we wa din                    ppp     ww     r0 r1 rv ra  exp d0                 exp d1                 busy   err
      step("reset",     1, 1, 5, ONES,                  3'b000, 2'b00, 5, 5, 1, 5,  Z,                     Z,                     2'b00, 1'b0);
      step("wr_r5_a",   0, 1, 5, 64'h0123456789ABCDEF, 3'b000, 2'b00, 1, 2, 0, 0,  Z,                     Z,                     2'b00, 1'b0);
      step("rd_r5",     0, 0, 0, Z,                     3'b000, 2'b00, 5, 0, 0, 0,  64'h0123456789ABCDEF, Z,                     2'b00, 1'b0);
      step("wr_r5_e8",  0, 1, 5, ONES,                  3'b011, 2'b00, 5, 5, 0, 0,  64'hFF23FF67FFABFFEF, 64'hFF23FF67FFABFFEF, 2'b00, 1'b0);
      step("wr_r5_o16", 0, 1, 5, ONES,                  3'b100, 2'b01, 5, 5, 0, 0,  64'hFF23FFFFFFABFFFF, 64'hFF23FFFFFFABFFFF, 2'b00, 1'b0);
      step("wr_r7_a",   0, 1, 7, 64'h1111111122222222, 3'b000, 2'b00, 5, 0, 0, 0,  64'hFF23FFFFFFABFFFF, Z,                     2'b00, 1'b0);
      step("wr_r7_u",   0, 1, 7, 64'hAAAAAAAABBBBBBBB, 3'b001, 2'b00, 7, 7, 0, 0,  64'hAAAAAAAA22222222, 64'hAAAAAAAA22222222, 2'b00, 1'b0);
      step("wr_r0",     0, 1, 0, ONES,                  3'b000, 2'b00, 0, 7, 0, 0,  Z,                     64'hAAAAAAAA22222222, 2'b00, 1'b0);
      step("wr_r3_a",   0, 1, 3, 64'h3333333333333333, 3'b000, 2'b00, 3, 0, 0, 0,  64'h3333333333333333, Z,                     2'b00, 1'b0);
      step("wr_r3_ill", 0, 1, 3, ONES,                  3'b110, 2'b00, 3, 0, 0, 0,  64'h3333333333333333, Z,                     2'b00, 1'b1);
      step("err_pulse", 0, 0, 0, Z,                     3'b000, 2'b00, 3, 0, 0, 0,  64'h3333333333333333, Z,                     2'b00, 1'b0);
      step("wr_r3_d",   0, 1, 3, Z,                     3'b010, 2'b00, 3, 3, 0, 0,  64'h3333333300000000, 64'h3333333300000000, 2'b00, 1'b0);
      step("wr_r3_o64", 0, 1, 3, ONES,                  3'b100, 2'b11, 3, 0, 0, 0,  64'h3333333300000000, Z,                     2'b00, 1'b0);
      step("wr_r3_e64", 0, 1, 3, 64'h0123456789ABCDEF, 3'b011, 2'b11, 0, 3, 0, 0,  Z,                     64'h0123456789ABCDEF, 2'b00, 1'b0);
      step("rsv_r9",    0, 0, 0, Z,                     3'b000, 2'b00, 9, 0, 1, 9,  Z,                     Z,                     2'b01, 1'b0);
      step("wr_rsv_r9", 0, 1, 9, 64'h9999999999999999, 3'b000, 2'b00, 9, 9, 1, 9,  64'h9999999999999999, 64'h9999999999999999, 2'b11, 1'b0);
      step("wr_r9",     0, 1, 9, Z,                     3'b000, 2'b00, 9, 9, 0, 0,  Z,                     Z,                     2'b00, 1'b0);
      step("rsv_r0",    0, 0, 0, Z,                     3'b000, 2'b00, 0, 0, 1, 0,  Z,                     Z,                     2'b00, 1'b0);
      step("rsv_r6",    0, 0, 0, Z,                     3'b000, 2'b00, 6, 0, 1, 6,  Z,                     Z,                     2'b01, 1'b0);
      step("ill_r6",    0, 1, 6, ONES,                  3'b111, 2'b00, 6, 0, 0, 0,  Z,                     Z,                     2'b00, 1'b1);
      step("rsv_wr_r4", 0, 1, 4, 64'h5555555555555555, 3'b000, 2'b00, 4, 4, 1, 4,  64'h5555555555555555, 64'h5555555555555555, 2'b11, 1'b0);
      step("reset_mid", 1, 1, 4, 64'hAAAAAAAAAAAAAAAA, 3'b000, 2'b00, 4, 4, 1, 4,  Z,                     Z,                     2'b00, 1'b0);
      step("post_rst",  0, 0, 0, Z,                     3'b000, 2'b00, 4, 4, 0, 0,  Z,                     Z,                     2'b00, 1'b0);
      step("b2b_1",     0, 1, 4, 64'hFFFF0000FFFF0000, 3'b000, 2'b00, 1, 1, 0, 0,  Z,                     Z,                     2'b00, 1'b0);
      step("b2b_2",     0, 1, 4, Z,                     3'b011, 2'b00, 1, 4, 0, 0,  Z,                     64'h00FF000000FF0000, 2'b00, 1'b0);
      step("b2b_rd",    0, 0, 0, Z,                     3'b000, 2'b00, 4, 0, 0, 0,  64'h00FF000000FF0000, Z,                     2'b00, 1'b0);
      @(negedge clk);
      #1;
      check("drain", "pending", 64'(expq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
